// File: rtl/unsigned_seq_divider.sv
// Sequential unsigned restoring divider: one quotient bit per clock, N cycles per operation.
// Optional macro SEQ_DIV_DBZ_DETECT_EN: short-circuits b=0 to a 1-cycle result with dbz=1.
module unsigned_seq_divider #(
  parameter int unsigned N = 24
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start_s,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] q,
  output logic [N-1:0] r,
  output logic         dbz
);

  localparam int unsigned CW = $clog2(N + 1);
  localparam logic [CW-1:0] NCNT = CW'(N);
  localparam logic [CW-1:0] LAST = CW'(1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DBZ} state_t;

  state_t         r_state;
  state_t         w_next;
  logic [N-1:0]   r_rem;
  logic [N-1:0]   r_qacc;
  logic [N-1:0]   r_div;
  logic [CW-1:0]  r_cnt;
  logic [N-1:0]   r_q;
  logic [N-1:0]   r_r;
  logic           r_done;
  logic [N:0]     w_shift;
  logic           w_ge;
  logic [N-1:0]   w_diff;
  logic [N-1:0]   w_rem_nxt;

  // The partial remainder always fits in N bits between steps; only the shifted
  // value needs the extra bit, so it is widened here rather than stored.
  assign w_shift   = {r_rem, r_qacc[N-1]};
  assign w_ge      = (w_shift >= {1'b0, r_div});
  assign w_diff    = w_shift[N-1:0] - r_div;
  assign w_rem_nxt = w_ge ? w_diff : w_shift[N-1:0];

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (start_s) begin
`ifdef SEQ_DIV_DBZ_DETECT_EN
          if (b == '0) w_next = S_DBZ;
          else         w_next = S_RUN;
`else
          w_next = S_RUN;
`endif
        end
      end
      S_RUN:   if (r_cnt == LAST) w_next = S_IDLE;
      S_DBZ:   w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

`ifdef SEQ_DIV_DBZ_DETECT_EN
  logic r_dbz;
  assign dbz = r_dbz;
`else
  assign dbz = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_rem   <= '0;
      r_qacc  <= '0;
      r_div   <= '0;
      r_cnt   <= '0;
      r_q     <= '0;
      r_r     <= '0;
      r_done  <= 1'b0;
`ifdef SEQ_DIV_DBZ_DETECT_EN
      r_dbz   <= 1'b0;
`endif
    end else begin
      r_state <= w_next;
      r_done  <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start_s) begin
            r_rem  <= '0;
            r_qacc <= a;
            r_div  <= b;
            r_cnt  <= NCNT;
          end
        end
        S_RUN: begin
          r_rem  <= w_rem_nxt;
          r_qacc <= {r_qacc[N-2:0], w_ge};
          r_cnt  <= r_cnt - LAST;
          if (r_cnt == LAST) begin
            r_q    <= {r_qacc[N-2:0], w_ge};
            r_r    <= w_rem_nxt;
            r_done <= 1'b1;
`ifdef SEQ_DIV_DBZ_DETECT_EN
            r_dbz  <= 1'b0;
`endif
          end
        end
`ifdef SEQ_DIV_DBZ_DETECT_EN
        S_DBZ: begin
          r_q    <= '1;
          r_r    <= r_qacc;
          r_dbz  <= 1'b1;
          r_done <= 1'b1;
        end
`endif
        default: ;
      endcase
    end
  end

  assign busy = (r_state != S_IDLE);
  assign done = r_done;
  assign q    = r_q;
  assign r    = r_r;

endmodule
